// File: rtl/framing_pkg.sv
// -----------------------------------------------------------------------------
// framing_pkg
// Shared definitions for the framing transmit path.
//   - arb_state_t       : framing_tx_arbiter FSM states (IDLE, HEADER, DATA)
//   - BYTE_W            : width of one stream byte
//   - FRAME_*_BYTE      : default START/STOP/ESCAPE octets, so the escaper and
//                         the framer stay consistent with each other
// No ports (package).
// -----------------------------------------------------------------------------
package framing_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] FRAME_START_BYTE  = 8'h7E;
   localparam logic [BYTE_W-1:0] FRAME_STOP_BYTE   = 8'h7E;
   localparam logic [BYTE_W-1:0] FRAME_ESCAPE_BYTE = 8'h7D;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } arb_state_t;

endpackage : framing_pkg

// File: rtl/framing_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority search. The channel after last_grant has
// the highest priority, wrapping modulo NUM_CHANNELS; last_grant itself has
// the lowest.
// Ports:
//   req        in   NUM_CHANNELS  request vector
//   last_grant in   IDW           most recently completed grant
//   winner     out  IDW           selected channel (0 when any_req=0)
//   any_req    out  1             at least one request present
// -----------------------------------------------------------------------------
module rr_picker
   import framing_pkg::*;
#(
   parameter  int NUM_CHANNELS = 4,
   localparam int IDW          = $clog2(NUM_CHANNELS)
) (
   input  logic [NUM_CHANNELS-1:0] req,
   input  logic [IDW-1:0]          last_grant,
   output logic [IDW-1:0]          winner,
   output logic                    any_req
);

   always_comb begin
      int idx;
      idx     = 0;
      winner  = '0;
      any_req = 1'b0;
      // Walk offsets 1..N from last_grant; the first hit wins.
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
         idx = (int'(last_grant) + k) % NUM_CHANNELS;
         if (!any_req && req[IDW'(idx)]) begin
            winner  = IDW'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule : rr_picker

// File: rtl/framing_tx_arbiter.sv
// -----------------------------------------------------------------------------
// framing_tx_arbiter
// Frame-granular round-robin arbiter sharing the TxFrame AXI4-Stream input of
// the framing block between NUM_CHANNELS byte-wide requesters. A grant is
// taken in IDLE and held until the granted channel's tlast handshake.
//
// Build option:
//   FRAMING_ARB_CHANNEL_ID_EN  defined   -> each output frame is prefixed by a
//                                           single channel-ID byte (grant_id)
//                              undefined -> frames pass through unmodified
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   ch_tvalid/tready   per-channel handshake (NUM_CHANNELS bits each)
//   ch_tdata           per-channel byte, channel i at [8i+7:8i]
//   ch_tlast           per-channel end of frame
//   txframe_*          merged stream toward the framer (tvalid/tready/tdata/tlast)
//   grant_id           currently granted channel, meaningful while busy=1
//   busy               high in HEADER or DATA
// -----------------------------------------------------------------------------
module framing_tx_arbiter
   import framing_pkg::*;
#(
   parameter  int NUM_CHANNELS = 4,
   localparam int IDW          = $clog2(NUM_CHANNELS)
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [NUM_CHANNELS-1:0]        ch_tvalid,
   output logic [NUM_CHANNELS-1:0]        ch_tready,
   input  logic [BYTE_W*NUM_CHANNELS-1:0] ch_tdata,
   input  logic [NUM_CHANNELS-1:0]        ch_tlast,
   output logic                           txframe_tvalid,
   input  logic                           txframe_tready,
   output logic [BYTE_W-1:0]              txframe_tdata,
   output logic                           txframe_tlast,
   output logic [IDW-1:0]                 grant_id,
   output logic                           busy
);

   arb_state_t        state, state_nxt;
   logic [IDW-1:0]    last_grant;
   logic [IDW-1:0]    winner;
   logic              any_req;
   logic              sel_valid;
   logic              sel_last;
   logic [BYTE_W-1:0] sel_data;
   logic              frame_done;

   rr_picker #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_rr_picker (
      .req        (ch_tvalid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_req    (any_req)
   );

   // Granted-channel view; only consumed in DATA.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_valid = ch_tvalid[i];
            sel_last  = ch_tlast[i];
            sel_data  = ch_tdata[BYTE_W*i +: BYTE_W];
         end
      end
   end

   assign frame_done = (state == ST_DATA) && sel_valid && txframe_tready && sel_last;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         grant_id   <= '0;
         last_grant <= IDW'(NUM_CHANNELS - 1);
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && any_req) begin
            grant_id <= winner;
         end
         if (frame_done) begin
            last_grant <= grant_id;
         end
      end
   end

   // Outputs are decoded from the state register so that during reset (state
   // forced to IDLE) everything drops to zero without waiting for a clock.
   always_comb begin
      state_nxt      = state;
      txframe_tvalid = 1'b0;
      txframe_tdata  = '0;
      txframe_tlast  = 1'b0;
      ch_tready      = '0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
`ifdef FRAMING_ARB_CHANNEL_ID_EN
               state_nxt = ST_HEADER;
`else
               state_nxt = ST_DATA;
`endif
            end
         end
`ifdef FRAMING_ARB_CHANNEL_ID_EN
         ST_HEADER: begin
            txframe_tvalid = 1'b1;
            txframe_tdata  = BYTE_W'(grant_id);
            if (txframe_tready) begin
               state_nxt = ST_DATA;
            end
         end
`endif
         ST_DATA: begin
            txframe_tvalid      = sel_valid;
            txframe_tdata       = sel_data;
            txframe_tlast       = sel_last;
            ch_tready[grant_id] = txframe_tready;
            if (frame_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule : framing_tx_arbiter

// File: tb/tb_framing_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_framing_tx_arbiter
// Directed scoreboard bench for framing_tx_arbiter (NUM_CHANNELS=4). Expected
// output bytes {grant, tlast, tdata} are queued when stimulus is issued and a
// negedge monitor pops/compares them on every txframe handshake. Works with
// FRAMING_ARB_CHANNEL_ID_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_framing_tx_arbiter;

   localparam int N = 4;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [N-1:0] ch_tvalid;
   logic [N-1:0] ch_tready;
   logic [8*N-1:0] ch_tdata;
   logic [N-1:0] ch_tlast;
   logic         txframe_tvalid;
   logic         txframe_tready;
   logic [7:0]   txframe_tdata;
   logic         txframe_tlast;
   logic [1:0]   grant_id;
   logic         busy;

   always #5 aclk = ~aclk;

   framing_tx_arbiter #(
      .NUM_CHANNELS (N)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .ch_tvalid      (ch_tvalid),
      .ch_tready      (ch_tready),
      .ch_tdata       (ch_tdata),
      .ch_tlast       (ch_tlast),
      .txframe_tvalid (txframe_tvalid),
      .txframe_tready (txframe_tready),
      .txframe_tdata  (txframe_tdata),
      .txframe_tlast  (txframe_tlast),
      .grant_id       (grant_id),
      .busy           (busy)
   );

   int checks = 0;
   int errors = 0;

   // Scoreboard: entry = {grant[1:0], tlast, tdata[7:0]}
   logic [10:0] exp_mem [64];
   int          exp_wr = 0;
   int          exp_rd = 0;
   logic [10:0] mon_e;
   logic        prev_last = 1'b0;
   logic [N-1:0] rdy_allow = '1;

   // Source byte queues per channel: entry = {tlast, tdata}
   logic [8:0]  src_mem [N][16];
   int          src_wr [N];
   int          src_rd [N];
   logic [N-1:0] hs;

   // ---------------- monitor ----------------
   always @(negedge aclk) begin
      if (ch_tready != '0) begin
         checks++;
         if ((ch_tready & ~rdy_allow) != '0) begin
            errors++;
            $display("FAIL ch_tready_iso: got %b, allowed %b", ch_tready, rdy_allow);
         end
      end
      if (prev_last) begin
         checks++;
         if (txframe_tvalid) begin
            errors++;
            $display("FAIL idle_bubble: txframe_tvalid=1 right after tlast, required 0");
         end
      end
      if (txframe_tvalid && txframe_tready) begin
         checks++;
         if (exp_rd == exp_wr) begin
            errors++;
            $display("FAIL out_unexpected: got grant=%0d last=%0b data=0x%02h, required no output",
                     grant_id, txframe_tlast, txframe_tdata);
         end else begin
            mon_e = exp_mem[exp_rd % 64];
            exp_rd++;
            if ({grant_id, txframe_tlast, txframe_tdata} !== mon_e || busy !== 1'b1) begin
               errors++;
               $display("FAIL out_byte #%0d: got grant=%0d last=%0b data=0x%02h busy=%0b, required grant=%0d last=%0b data=0x%02h busy=1",
                        exp_rd - 1, grant_id, txframe_tlast, txframe_tdata, busy,
                        mon_e[10:9], mon_e[8], mon_e[7:0]);
            end
         end
      end
      prev_last = txframe_tvalid && txframe_tready && txframe_tlast;
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
      end
   endtask

   task automatic push_src(input int ch, input logic [7:0] d, input logic l);
      src_mem[ch][src_wr[ch] % 16] = {l, d};
      src_wr[ch]++;
   endtask

   task automatic push_exp(input logic [1:0] g, input logic [7:0] d, input logic l);
      exp_mem[exp_wr % 64] = {g, l, d};
      exp_wr++;
   endtask

   task automatic push_hdr(input logic [1:0] g, input logic [7:0] d);
`ifdef FRAMING_ARB_CHANNEL_ID_EN
      push_exp(g, d, 1'b0);
`else
      if (g != 2'd0 && d == 8'hFF) $display("unused header %0d", g);
`endif
   endtask

   task automatic drive();
      for (int ch = 0; ch < N; ch++) begin
         if (src_rd[ch] < src_wr[ch]) begin
            ch_tvalid[ch] = 1'b1;
            {ch_tlast[ch], ch_tdata[8*ch +: 8]} = src_mem[ch][src_rd[ch] % 16];
         end else begin
            ch_tvalid[ch]        = 1'b0;
            ch_tlast[ch]         = 1'b0;
            ch_tdata[8*ch +: 8]  = 8'h00;
         end
      end
   endtask

   // One clock: capture source handshakes in the low phase, advance sources
   // just after the rising edge.
   task automatic tick();
      @(negedge aclk);
      #1;
      hs = ch_tvalid & ch_tready;
      @(posedge aclk);
      #1;
      for (int ch = 0; ch < N; ch++) begin
         if (hs[ch]) src_rd[ch]++;
      end
      drive();
   endtask

   function automatic logic all_idle();
      logic r;
      r = (exp_rd == exp_wr) && !busy;
      for (int ch = 0; ch < N; ch++) begin
         if (src_rd[ch] != src_wr[ch]) r = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_drain(input string name, input int max_cyc);
      int n;
      n = 0;
      while (!all_idle() && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL %s_drain: %0d of %0d expected bytes seen after %0d cycles, required all",
                  name, exp_rd, exp_wr, n);
      end
   endtask

   task automatic wait_remaining(input string name, input int rem, input int max_cyc);
      int n;
      n = 0;
      while ((exp_wr - exp_rd) > rem && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL %s_wait: %0d bytes outstanding, required %0d", name, exp_wr - exp_rd, rem);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      for (int ch = 0; ch < N; ch++) src_rd[ch] = src_wr[ch];
      drive();
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      aresetn        = 1'b0;
      txframe_tready = 1'b1;
      hs             = '0;
      for (int ch = 0; ch < N; ch++) begin
         src_wr[ch] = 0;
         src_rd[ch] = 0;
      end
      drive();
      #2;
      chk("rst_tvalid",   {31'd0, txframe_tvalid}, 32'd0);
      chk("rst_tlast",    {31'd0, txframe_tlast},  32'd0);
      chk("rst_tdata",    {24'd0, txframe_tdata},  32'd0);
      chk("rst_ch_tready",{28'd0, ch_tready},      32'd0);
      chk("rst_busy",     {31'd0, busy},           32'd0);
      chk("rst_grant_id", {30'd0, grant_id},       32'd0);
      tick();
      tick();
      aresetn = 1'b1;
      tick();

      // T1: ch1 alone sends {0x11, 0x22}; only ch_tready[1] may ever rise.
      rdy_allow = 4'b0010;
      push_src(1, 8'h11, 1'b0);
      push_src(1, 8'h22, 1'b1);
      push_hdr(2'd1, 8'h01);
      push_exp(2'd1, 8'h11, 1'b0);
      push_exp(2'd1, 8'h22, 1'b1);
      drive();
      wait_drain("t1", 40);
      rdy_allow = '1;

      // T2: all channels loaded at once from reset: order ch0,ch1,ch2,ch3,ch0.
      do_reset();
      push_src(0, 8'h00, 1'b0); push_src(0, 8'h01, 1'b1);
      push_src(0, 8'h02, 1'b0); push_src(0, 8'h03, 1'b1);
      push_src(1, 8'h10, 1'b0); push_src(1, 8'h11, 1'b1);
      push_src(2, 8'h20, 1'b0); push_src(2, 8'h21, 1'b1);
      push_src(3, 8'h30, 1'b0); push_src(3, 8'h31, 1'b1);
      push_hdr(2'd0, 8'h00); push_exp(2'd0, 8'h00, 1'b0); push_exp(2'd0, 8'h01, 1'b1);
      push_hdr(2'd1, 8'h01); push_exp(2'd1, 8'h10, 1'b0); push_exp(2'd1, 8'h11, 1'b1);
      push_hdr(2'd2, 8'h02); push_exp(2'd2, 8'h20, 1'b0); push_exp(2'd2, 8'h21, 1'b1);
      push_hdr(2'd3, 8'h03); push_exp(2'd3, 8'h30, 1'b0); push_exp(2'd3, 8'h31, 1'b1);
      push_hdr(2'd0, 8'h00); push_exp(2'd0, 8'h02, 1'b0); push_exp(2'd0, 8'h03, 1'b1);
      drive();
      wait_drain("t2", 80);

      // T3: ch2 frame stalled by txframe_tready low for 5 cycles at byte 0xA2.
      push_src(2, 8'hA0, 1'b0); push_src(2, 8'hA1, 1'b0);
      push_src(2, 8'hA2, 1'b0); push_src(2, 8'hA3, 1'b1);
      push_hdr(2'd2, 8'h02);
      push_exp(2'd2, 8'hA0, 1'b0); push_exp(2'd2, 8'hA1, 1'b0);
      push_exp(2'd2, 8'hA2, 1'b0); push_exp(2'd2, 8'hA3, 1'b1);
      drive();
      wait_remaining("t3", 2, 40);
      txframe_tready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t3_stall_tdata",  {24'd0, txframe_tdata},  32'h0000_00A2);
         chk("t3_stall_tvalid", {31'd0, txframe_tvalid}, 32'd1);
         chk("t3_stall_rdy2",   {31'd0, ch_tready[2]},   32'd0);
      end
      txframe_tready = 1'b1;
      wait_drain("t3", 40);

      // T4: ch3 mid-frame when ch0 starts requesting; ch0 waits for ch3's tlast.
      push_src(3, 8'h34, 1'b0); push_src(3, 8'h35, 1'b0);
      push_src(3, 8'h36, 1'b0); push_src(3, 8'h37, 1'b1);
      push_hdr(2'd3, 8'h03);
      push_exp(2'd3, 8'h34, 1'b0); push_exp(2'd3, 8'h35, 1'b0);
      push_exp(2'd3, 8'h36, 1'b0); push_exp(2'd3, 8'h37, 1'b1);
      drive();
      wait_remaining("t4", 3, 40);
      push_src(0, 8'h05, 1'b0); push_src(0, 8'h06, 1'b1);
      push_hdr(2'd0, 8'h00);
      push_exp(2'd0, 8'h05, 1'b0); push_exp(2'd0, 8'h06, 1'b1);
      drive();
      tick();
      chk("t4_grant_hold", {30'd0, grant_id}, 32'd3);
      wait_drain("t4", 40);

      // T5: reset pulsed after 2 of 4 bytes of a ch1 frame.
      do_reset();
      push_src(1, 8'h40, 1'b0); push_src(1, 8'h41, 1'b0);
      push_src(1, 8'h42, 1'b0); push_src(1, 8'h43, 1'b1);
      push_hdr(2'd1, 8'h01);
      push_exp(2'd1, 8'h40, 1'b0); push_exp(2'd1, 8'h41, 1'b0);
      drive();
      wait_remaining("t5", 0, 40);
      #2;
      aresetn = 1'b0;
      #1;
      chk("t5_rst_tvalid",   {31'd0, txframe_tvalid}, 32'd0);
      chk("t5_rst_tlast",    {31'd0, txframe_tlast},  32'd0);
      chk("t5_rst_tdata",    {24'd0, txframe_tdata},  32'd0);
      chk("t5_rst_ch_tready",{28'd0, ch_tready},      32'd0);
      chk("t5_rst_busy",     {31'd0, busy},           32'd0);
      chk("t5_rst_grant_id", {30'd0, grant_id},       32'd0);
      src_rd[1] = src_wr[1];
      drive();
      tick();
      tick();
      aresetn = 1'b1;
      push_src(1, 8'h50, 1'b0); push_src(1, 8'h51, 1'b1);
      push_src(2, 8'h60, 1'b0); push_src(2, 8'h61, 1'b1);
      push_hdr(2'd1, 8'h01); push_exp(2'd1, 8'h50, 1'b0); push_exp(2'd1, 8'h51, 1'b1);
      push_hdr(2'd2, 8'h02); push_exp(2'd2, 8'h60, 1'b0); push_exp(2'd2, 8'h61, 1'b1);
      drive();
      wait_drain("t5", 60);

      // T6: single-byte frame 0x7E on ch2; FSM idle on the following cycle.
      push_src(2, 8'h7E, 1'b1);
      push_hdr(2'd2, 8'h02);
      push_exp(2'd2, 8'h7E, 1'b1);
      drive();
      wait_remaining("t6", 0, 40);
      chk("t6_busy_after",   {31'd0, busy},           32'd0);
      chk("t6_tvalid_after", {31'd0, txframe_tvalid}, 32'd0);
      wait_drain("t6", 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "global timeout");
   end

endmodule : tb_framing_tx_arbiter
